alu_i8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-bit logic/arithmetic unit (xor, and, or, add) among four requesters over valid/ready handshakes. It sits between compiled requester blocks and a single shared `i8` operator, so four logical operators map onto one physical unit. Results return on a single response channel tagged with the requester id. The response path is back-pressured, and one result buffer (two with the pipeline option) holds results until the consumer takes them.

---
 rtl/alu_i8_rr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_i8_rr_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_i8_rr_arbiter.sv
// alu_i8_rr_arbiter: four requesters share one 8-bit xor/and/or/add unit.
// A round-robin grant picks one valid requester per cycle. Its result is
// returned on a single back-pressured response channel, tagged with the
// requester id.
//
// Optional feature macro: ALU_ARB_PIPE_EN. When it is defined, an issue
// register stage is added ahead of the operator, and latency becomes 2.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [3:0]   per-requester request valid
//   req_ready  out  [3:0]   one-hot combinational grant
//   req_op     in   [7:0]   2-bit op per requester (00 xor, 01 and, 10 or, 11 add)
//   req_a      in   [31:0]  8-bit operand a per requester
//   req_b      in   [31:0]  8-bit operand b per requester
//   rsp_valid  out          result valid
//   rsp_ready  in           consumer accept
//   rsp_id     out  [1:0]   owner of the result
//   rsp_y      out  [7:0]   result
module alu_i8_rr_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [7:0]  rsp_y
);

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 2;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [OPW-1:0] OP_XOR = 2'b00;
  localparam logic [OPW-1:0] OP_AND = 2'b01;
  localparam logic [OPW-1:0] OP_OR  = 2'b10;
  localparam logic [OPW-1:0] OP_ADD = 2'b11;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [IDW-1:0] ptr;
  logic           slot_free;
  logic           grant_ok;
  logic           accept;
  logic           found;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] grant_idx;
  logic [N-1:0]   grant;
  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic           load;
  logic [IDW-1:0] ld_id;
  logic [OPW-1:0] ld_op;
  logic [DW-1:0]  ld_a;
  logic [DW-1:0]  ld_b;

  function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op,
                                          input logic [DW-1:0]  a,
                                          input logic [DW-1:0]  b);
    logic [DW-1:0] y;
    y = '0;
    case (op)
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;  // carry discarded
      default: y = '0;
    endcase
    return y;
  endfunction

  assign rsp_valid = (state == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // Round-robin search: first valid requester starting at ptr.
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr;
    scan_idx  = ptr;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr + IDW'(k);
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign accept = found && grant_ok;

  always_comb begin
    grant = '0;
    if (accept) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  // Operands of the granted requester.
  assign sel_op = req_op[{grant_idx, 1'b0} +: OPW];
  assign sel_a  = req_a[{grant_idx, 3'b000} +: DW];
  assign sel_b  = req_b[{grant_idx, 3'b000} +: DW];

`ifdef ALU_ARB_PIPE_EN
  logic           iss_valid;
  logic [IDW-1:0] iss_id;
  logic [OPW-1:0] iss_op;
  logic [DW-1:0]  iss_a;
  logic [DW-1:0]  iss_b;

  // Issue stage refills whenever it is empty or moving into the result slot.
  assign grant_ok = !reset && (!iss_valid || slot_free);
  assign load     = iss_valid && slot_free;
  assign ld_id    = iss_id;
  assign ld_op    = iss_op;
  assign ld_a     = iss_a;
  assign ld_b     = iss_b;

  // Issue register stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_op    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_id    <= grant_idx;
      iss_op    <= sel_op;
      iss_a     <= sel_a;
      iss_b     <= sel_b;
    end else if (load) begin
      iss_valid <= 1'b0;
    end
  end
`else
  assign grant_ok = !reset && slot_free;
  assign load     = accept;
  assign ld_id    = grant_idx;
  assign ld_op    = sel_op;
  assign ld_a     = sel_a;
  assign ld_b     = sel_b;
`endif

  // Round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= grant_idx + IDW'(1);
  end

  // Result slot state register.
  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Result slot next state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (!load && rsp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Result register; load only occurs when the slot is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_id <= '0;
      rsp_y  <= '0;
    end else if (load) begin
      rsp_id <= ld_id;
      rsp_y  <= alu_f(ld_op, ld_a, ld_b);
    end
  end

endmodule

// File: tb/tb_alu_i8_rr_arbiter.sv
// Directed self-checking bench for alu_i8_rr_arbiter (default single-stage build).
module tb_alu_i8_rr_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_y;

  int n_cmp;
  int n_bad;

  alu_i8_rr_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0:    return a ^ b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return s[7:0];
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'h11, 8'h22);
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_req_ready cyc=%0d got=%b exp=0000", c, req_ready);
      end
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_rsp_valid cyc=%0d got=%b exp=0", c, rsp_valid);
      end
      n_cmp++;
      if (rsp_y !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_rsp_y cyc=%0d got=%h exp=00", c, rsp_y);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_single_op();
    @(negedge clock);
    rsp_ready = 1'b1;
    set_req(2, 2'b00, 8'd3, 8'd12);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_grant got=%b exp=0100", req_ready);
    end
    @(negedge clock);
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'd15 || rsp_id !== 2'd2) begin
      n_bad++;
      $display("FAIL single_xor got v=%b id=%0d y=%0d exp v=1 id=2 y=15", rsp_valid, rsp_id, rsp_y);
    end
    set_req(2, 2'b11, 8'd200, 8'd100);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_add_grant got=%b exp=0100", req_ready);
    end
    @(negedge clock);
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'd44 || rsp_id !== 2'd2) begin
      n_bad++;
      $display("FAIL single_add_wrap got v=%b id=%0d y=%0d exp v=1 id=2 y=44", rsp_valid, rsp_id, rsp_y);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] rr_y [4];
    logic [3:0] exp_g;
    rr_y = '{8'hCC, 8'h30, 8'hFC, 8'h2C};
    pulse_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'hF0, 8'h3C);
    req_valid = 4'hF;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_y !== rr_y[(c - 1) % 4]) begin
          n_bad++;
          $display("FAIL rr_result step=%0d got v=%b id=%0d y=%h exp v=1 id=%0d y=%h",
                   c, rsp_valid, rsp_id, rsp_y, (c - 1) % 4, rr_y[(c - 1) % 4]);
        end
      end
      if (c < 5) begin
        exp_g = 4'(1 << (c % 4));
        n_cmp++;
        if (req_ready !== exp_g) begin
          n_bad++;
          $display("FAIL rr_grant step=%0d got=%b exp=%b", c, req_ready, exp_g);
        end
        @(negedge clock);
        #1;
      end else begin
        req_valid = 4'b0000;
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    set_req(1, 2'b11, 8'd5, 8'd7);
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_first_grant got=%b exp=0010", req_ready);
    end
    @(negedge clock);
    #1;
    set_req(1, 2'b00, 8'd9, 8'd3);
    for (int s = 0; s < 5; s++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", s, req_ready);
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'd12 || rsp_id !== 2'd1) begin
        n_bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b id=%0d y=%0d exp v=1 id=1 y=12", s, rsp_valid, rsp_id, rsp_y);
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_drain_accept got=%b exp=0010", req_ready);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'd10 || rsp_id !== 2'd1) begin
      n_bad++;
      $display("FAIL bp_next_result got v=%b id=%0d y=%0d exp v=1 id=1 y=10", rsp_valid, rsp_id, rsp_y);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_fairness();
    logic [3:0] pend;
    logic [3:0] exp_g;
    logic [1:0] mptr;
    logic [1:0] gi;
    logic [1:0] idx;
    logic [1:0] f_op [4];
    logic [7:0] f_a [4];
    logic [7:0] f_b [4];
    logic       have_exp;
    logic [1:0] exp_id;
    logic [7:0] exp_y;
    int         wait3;
    pulse_reset();
    rsp_ready = 1'b1;
    pend      = 4'b0000;
    mptr      = 2'd0;
    gi        = 2'd0;
    have_exp  = 1'b0;
    exp_id    = 2'd0;
    exp_y     = 8'd0;
    wait3     = 0;
    for (int i = 0; i < 4; i++) begin
      f_op[i] = 2'd0;
      f_a[i]  = 8'd0;
      f_b[i]  = 8'd0;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && (i == 3 || $urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          f_op[i] = 2'($urandom_range(0, 3));
          f_a[i]  = 8'($urandom_range(0, 255));
          f_b[i]  = 8'($urandom_range(0, 255));
          set_req(i, f_op[i], f_a[i], f_b[i]);
        end
      end
      req_valid = pend;
      #1;
      n_cmp++;
      if (have_exp) begin
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_y !== exp_y) begin
          n_bad++;
          $display("FAIL fair_result cyc=%0d got v=%b id=%0d y=%h exp v=1 id=%0d y=%h",
                   cyc, rsp_valid, rsp_id, rsp_y, exp_id, exp_y);
        end
      end else if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL fair_idle cyc=%0d got v=%b exp v=0", cyc, rsp_valid);
      end
      exp_g = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        idx = mptr + 2'(k);
        if (exp_g == 4'b0000 && pend[idx]) begin
          exp_g[idx] = 1'b1;
          gi         = idx;
        end
      end
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_bad++;
        $display("FAIL fair_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_g);
      end
      // Requester 3 wait measured from the DUT's own grants.
      if (req_ready[3] === 1'b1) begin
        n_cmp++;
        if (wait3 > 3) begin
          n_bad++;
          $display("FAIL fair_starve cyc=%0d got=%0d other accepts exp<=3", cyc, wait3);
        end
        wait3 = 0;
      end else if (req_ready !== 4'b0000) begin
        wait3++;
      end
      have_exp = 1'b1;
      exp_id   = gi;
      exp_y    = ref_alu(f_op[gi], f_a[gi], f_b[gi]);
      pend[gi] = 1'b0;
      mptr     = gi + 2'd1;
    end
    @(negedge clock);
    req_valid = 4'b0000;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_y !== exp_y) begin
      n_bad++;
      $display("FAIL fair_last got v=%b id=%0d y=%h exp v=1 id=%0d y=%h", rsp_valid, rsp_id, rsp_y, exp_id, exp_y);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 8'd1, 8'd2);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_grant got=%b exp=0001", req_ready);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'd3) begin
      n_bad++;
      $display("FAIL mid_setup got v=%b y=%0d exp v=1 y=3", rsp_valid, rsp_y);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset_ready got=%b exp=0000", req_ready);
    end
    @(negedge clock);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_y !== 8'd0 || rsp_id !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_cleared got v=%b id=%0d y=%0d exp v=0 id=0 y=0", rsp_valid, rsp_id, rsp_y);
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_stale cyc=%0d got v=%b exp v=0", c, rsp_valid);
      end
    end
    set_req(2, 2'b01, 8'hFF, 8'h0F);
    req_valid = 4'b0101;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_ptr_zero got=%b exp=0001", req_ready);
    end
    @(negedge clock);
    req_valid = 4'b0000;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single_op();
    test_round_robin();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
